// File: rtl/shadow_reg_bank_pkg.sv
// Shared encodings and the write-mode helper for shadow_reg_bank.
// Optional transparent mode is enabled with SHADOW_REG_BANK_TRANSP_EN (see top).
package shadow_reg_bank_pkg;

    localparam int MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        LOAD = 2'b00,
        SET  = 2'b01,
        CLR  = 2'b10,
        TOG  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } state_e;

    // All modes are bitwise, so narrower callers zero-extend in and truncate the result.
    function automatic logic [MAX_WIDTH-1:0] apply_mode(
        input logic [MAX_WIDTH-1:0] old_val,
        input logic [MAX_WIDTH-1:0] data,
        input mode_e                mode
    );
        logic [MAX_WIDTH-1:0] res;
        case (mode)
            LOAD:    res = data;
            SET:     res = old_val | data;
            CLR:     res = old_val & ~data;
            default: res = old_val ^ data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/shadow_reg_chan.sv
// One channel of shadow_reg_bank: shadow register, active register and dirty flag.
// The shadow only ever reaches the active register through a copy strobe.
module shadow_reg_chan
    import shadow_reg_bank_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_hit,
    input  mode_e            wr_mode,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             copy,
    output logic [WIDTH-1:0] q,
    output logic             dirty
);

    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] next_val;

    assign next_val = WIDTH'(apply_mode(MAX_WIDTH'(shadow), MAX_WIDTH'(wr_data), wr_mode));

    // NOTE: non-blocking assignments here so every register samples the pre-edge values,
    // which is what makes a same-cycle write and copy well defined below.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow <= RST_VAL;
            q      <= RST_VAL;
            dirty  <= 1'b0;
        end else begin
            if (wr_hit) begin
                shadow <= next_val;
            end
            if (copy && dirty) begin
                q <= shadow;
            end
            // A write coinciding with a copy stays dirty: the copy took the old shadow.
            if (wr_hit) begin
                dirty <= 1'b1;
            end else if (copy) begin
                dirty <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/shadow_reg_bank.sv
// Multi-channel shadow/active register bank with a fixed-latency commit scan.
// Define SHADOW_REG_BANK_TRANSP_EN to add the transp port (transparent mode in IDLE).
module shadow_reg_bank
    import shadow_reg_bank_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               CHANNELS = 4,
    parameter int               CH_W     = $clog2(CHANNELS),
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef SHADOW_REG_BANK_TRANSP_EN
    input  logic                      transp,
`endif
    input  logic                      wr_en,
    output logic                      wr_ready,
    input  logic [CH_W-1:0]           wr_ch,
    input  logic [1:0]                wr_mode,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      commit_req,
    output logic                      commit_ack,
    output logic                      busy,
    output logic [CHANNELS-1:0]       dirty,
    output logic [CHANNELS*WIDTH-1:0] q
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

    state_e              state;
    logic [CH_W-1:0]     ptr;
    logic                wr_acc;
    logic                transp_on;
    logic [CHANNELS-1:0] wr_hit;
    logic [CHANNELS-1:0] copy;
    mode_e               mode;

    assign mode     = mode_e'(wr_mode);
    assign wr_ready = (state == IDLE);
    assign wr_acc   = wr_en && wr_ready;

`ifdef SHADOW_REG_BANK_TRANSP_EN
    assign transp_on = transp && (state == IDLE);
`else
    assign transp_on = 1'b0;
`endif

    // Out-of-range channel indices match no channel, so such writes vanish.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        assign wr_hit[i] = wr_acc && (wr_ch == CH_W'(i));
        assign copy[i]   = transp_on || ((state == SCAN) && (ptr == CH_W'(i)));

        shadow_reg_chan #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .wr_hit  (wr_hit[i]),
            .wr_mode (mode),
            .wr_data (wr_data),
            .copy    (copy[i]),
            .q       (q[i*WIDTH +: WIDTH]),
            .dirty   (dirty[i])
        );
    end

    // The scan always visits every channel so commit latency is fixed at CHANNELS+1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ptr        <= '0;
            busy       <= 1'b0;
            commit_ack <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (commit_req) begin
                        ptr  <= '0;
                        busy <= 1'b1;
                        // A write accepted this same cycle counts toward the commit.
                        if (!transp_on && (|(dirty | wr_hit))) begin
                            state <= SCAN;
                        end else begin
                            state      <= DONE;
                            commit_ack <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (ptr == LAST_CH) begin
                        state      <= DONE;
                        ptr        <= '0;
                        commit_ack <= 1'b1;
                    end else begin
                        ptr <= ptr + CH_W'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    commit_ack <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shadow_reg_bank.sv
// Self-checking bench for shadow_reg_bank: directed steps plus random writes/commits
// checked against an array-based reference model.
`timescale 1ns/1ps
module tb_shadow_reg_bank;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int CH_W     = 2;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic                      wr_en = 1'b0;
    logic [CH_W-1:0]           wr_ch = '0;
    logic [1:0]                wr_mode = '0;
    logic [WIDTH-1:0]          wr_data = '0;
    logic                      commit_req = 1'b0;
    logic                      wr_ready, commit_ack, busy;
    logic [CHANNELS-1:0]       dirty;
    logic [CHANNELS*WIDTH-1:0] q;
`ifdef SHADOW_REG_BANK_TRANSP_EN
    logic                      transp = 1'b0;
`endif

    // Second instance with a non-power-of-two channel count, so out-of-range indices exist.
    logic                      wr_en5 = 1'b0;
    logic [2:0]                wr_ch5 = '0;
    logic                      commit_req5 = 1'b0;
    logic                      wr_ready5, commit_ack5, busy5;
    logic [4:0]                dirty5;
    logic [5*WIDTH-1:0]        q5;

    int tests = 0;
    int fails = 0;

    logic [WIDTH-1:0]    sh_m [CHANNELS];
    logic [WIDTH-1:0]    ac_m [CHANNELS];
    logic [CHANNELS-1:0] dt_m;
    bit                  transp_m = 1'b0;

    always #5 clk = ~clk;

    shadow_reg_bank #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) u_dut (
        .clk        (clk),
        .rst        (rst),
`ifdef SHADOW_REG_BANK_TRANSP_EN
        .transp     (transp),
`endif
        .wr_en      (wr_en),
        .wr_ready   (wr_ready),
        .wr_ch      (wr_ch),
        .wr_mode    (wr_mode),
        .wr_data    (wr_data),
        .commit_req (commit_req),
        .commit_ack (commit_ack),
        .busy       (busy),
        .dirty      (dirty),
        .q          (q)
    );

    shadow_reg_bank #(.WIDTH(WIDTH), .CHANNELS(5)) u_dut5 (
        .clk        (clk),
        .rst        (rst),
`ifdef SHADOW_REG_BANK_TRANSP_EN
        .transp     (1'b0),
`endif
        .wr_en      (wr_en5),
        .wr_ready   (wr_ready5),
        .wr_ch      (wr_ch5),
        .wr_mode    (wr_mode),
        .wr_data    (wr_data),
        .commit_req (commit_req5),
        .commit_ack (commit_ack5),
        .busy       (busy5),
        .dirty      (dirty5),
        .q          (q5)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] mode_ref(input logic [WIDTH-1:0] old_v,
                                                  input logic [WIDTH-1:0] d,
                                                  input logic [1:0] m);
        case (m)
            2'd0:    return d;
            2'd1:    return old_v | d;
            2'd2:    return old_v & ~d;
            default: return old_v ^ d;
        endcase
    endfunction

    function automatic logic [CHANNELS*WIDTH-1:0] q_ref();
        logic [CHANNELS*WIDTH-1:0] r;
        for (int i = 0; i < CHANNELS; i++) r[i*WIDTH +: WIDTH] = ac_m[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CHANNELS; i++) begin
            sh_m[i] = '0;
            ac_m[i] = '0;
        end
        dt_m = '0;
    endtask

    task automatic model_write(input int ch, input logic [1:0] m, input logic [WIDTH-1:0] d);
        sh_m[ch] = mode_ref(sh_m[ch], d, m);
        dt_m[ch] = 1'b1;
    endtask

    task automatic model_commit();
        for (int i = 0; i < CHANNELS; i++) if (dt_m[i]) ac_m[i] = sh_m[i];
        dt_m = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".q"}, 64'(q), 64'(q_ref()));
        check({tag, ".dirty"}, 64'(dirty), 64'(dt_m));
    endtask

    task automatic do_write(input int ch, input logic [1:0] m, input logic [WIDTH-1:0] d);
        check("write.ready", 64'(wr_ready), 64'(1));
        wr_en   = 1'b1;
        wr_ch   = CH_W'(ch);
        wr_mode = m;
        wr_data = d;
        tick();
        wr_en = 1'b0;
        model_write(ch, m, d);
        check_state("write");
    endtask

    // Raises commit_req for one cycle (any write already driven rides along) and waits for the ack.
    task automatic run_commit(input string tag);
        int n;
        int exp_lat;
        exp_lat    = (dt_m != '0 && !transp_m) ? CHANNELS + 1 : 1;
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        wr_en      = 1'b0;
        n = 1;
        while (!commit_ack && n < 20) begin
            check({tag, ".busy"}, 64'(busy), 64'(1));
            check({tag, ".ready_low"}, 64'(wr_ready), 64'(0));
            tick();
            n++;
        end
        check({tag, ".latency"}, 64'(n), 64'(exp_lat));
        check({tag, ".busy_done"}, 64'(busy), 64'(1));
        model_commit();
        tick();
        check({tag, ".ack_pulse"}, 64'(commit_ack), 64'(0));
        check({tag, ".busy_clear"}, 64'(busy), 64'(0));
        check_state(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int nw;

        // Reset state
        model_reset();
        #12;
        check("rst.q", 64'(q), 64'(0));
        check("rst.dirty", 64'(dirty), 64'(0));
        check("rst.busy", 64'(busy), 64'(0));
        check("rst.ack", 64'(commit_ack), 64'(0));
        check("rst.ready", 64'(wr_ready), 64'(1));
        rst = 1'b1;
        tick();

        // Reset mid-SCAN
        do_write(1, 2'd0, 8'hA5);
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        tick();
        check("midscan.busy", 64'(busy), 64'(1));
        rst = 1'b0;
        #1;
        model_reset();
        check("midscan_rst.q", 64'(q), 64'(0));
        check("midscan_rst.dirty", 64'(dirty), 64'(0));
        check("midscan_rst.busy", 64'(busy), 64'(0));
        repeat (3) begin
            tick();
            check("midscan_rst.ack", 64'(commit_ack), 64'(0));
        end
        rst = 1'b1;
        tick();
        check_state("after_rst");

        // Write modes on ch2: 0x0F | 0xF0 = 0xFF, & ~0x3C = 0xC3, ^ 0xFF = 0x3C
        do_write(2, 2'd0, 8'h0F);
        do_write(2, 2'd1, 8'hF0);
        do_write(2, 2'd2, 8'h3C);
        do_write(2, 2'd3, 8'hFF);
        check("modes.q2_before", 64'(q[23:16]), 64'(8'h00));
        run_commit("modes");
        check("modes.q2_after", 64'(q[23:16]), 64'(8'h3C));

`ifdef SHADOW_REG_BANK_TRANSP_EN
        // Transparent mode: write shows up on q one cycle after acceptance
        transp   = 1'b1;
        transp_m = 1'b1;
        wr_en   = 1'b1;
        wr_ch   = 2'd3;
        wr_mode = 2'd0;
        wr_data = 8'h99;
        tick();
        wr_en = 1'b0;
        model_write(3, 2'd0, 8'h99);
        tick();
        model_commit();
        check("transp.q3", 64'(q[31:24]), 64'(8'h99));
        check("transp.dirty3", 64'(dirty[3]), 64'(0));
        check_state("transp");
        // Dirty channel plus commit_req under transp behaves as an empty commit
        do_write(3, 2'd3, 8'hFF);
        run_commit("transp_commit");
        check("transp_commit.q3", 64'(q[31:24]), 64'(8'h66));
        transp   = 1'b0;
        transp_m = 1'b0;
`else
        do_write(3, 2'd0, 8'h99);
        check("no_transp.q3", 64'(q[31:24]), 64'(8'h00));
        run_commit("no_transp_commit");
        check("no_transp_commit.q3", 64'(q[31:24]), 64'(8'h99));
`endif

        // Commit latency with dirty = 0b0101
        do_write(0, 2'd0, 8'h12);
        do_write(2, 2'd1, 8'h81);
        check("lat.dirty", 64'(dirty), 64'(4'b0101));
        run_commit("lat");

        // Write while busy is stalled, retry after ack is accepted
        do_write(1, 2'd3, 8'h5A);
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        wr_en   = 1'b1;
        wr_ch   = 2'd0;
        wr_mode = 2'd0;
        wr_data = 8'h77;
        n = 1;
        while (!commit_ack && n < 20) begin
            check("busy_wr.ready", 64'(wr_ready), 64'(0));
            tick();
            n++;
        end
        check("busy_wr.latency", 64'(n), 64'(CHANNELS + 1));
        check("busy_wr.ready_done", 64'(wr_ready), 64'(0));
        wr_en = 1'b0;
        model_commit();
        tick();
        check_state("busy_wr");
        do_write(0, 2'd0, 8'h77);
        run_commit("retry");
        check("retry.q0", 64'(q[7:0]), 64'(8'h77));

        // Simultaneous write and commit_req in IDLE
        wr_en   = 1'b1;
        wr_ch   = 2'd0;
        wr_mode = 2'd0;
        wr_data = 8'h55;
        model_write(0, 2'd0, 8'h55);
        run_commit("simul");
        check("simul.q0", 64'(q[7:0]), 64'(8'h55));

        // Empty commit
        run_commit("empty");

        // Out-of-range channel on the 5-channel instance, then an in-range control write
        wr_en5  = 1'b1;
        wr_mode = 2'd0;
        wr_data = 8'hEE;
        wr_ch5  = 3'd5;
        tick();
        wr_ch5 = 3'd7;
        tick();
        check("oor.dirty", 64'(dirty5), 64'(0));
        check("oor.q", 64'(q5), 64'(0));
        wr_ch5 = 3'd4;
        tick();
        wr_en5 = 1'b0;
        check("oor.in_range_dirty", 64'(dirty5), 64'(5'b10000));
        check("oor.q_unchanged", 64'(q5), 64'(0));
        check("oor.ready", 64'(wr_ready5), 64'(1));
        check("oor.busy", 64'(busy5), 64'(0));
        check("oor.ack", 64'(commit_ack5), 64'(0));

        // Random writes and commits against the model
        for (int it = 0; it < 40; it++) begin
            nw = $urandom_range(0, 3);
            for (int k = 0; k < nw; k++) begin
                do_write($urandom_range(0, CHANNELS - 1), 2'($urandom_range(0, 3)), 8'($urandom));
            end
            if ($urandom_range(0, 1) == 1) run_commit("rand");
        end
        run_commit("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
